// File: rtl/mux4_stream_arbiter_pkg.sv
// Shared types for the 4-way round-robin stream arbiter.
// Grant index type, FSM states and requester count.
package mux4_arb_pkg;

  localparam int NREQ = 4;

  typedef enum logic [0:0] {
    IDLE,
    BUSY
  } arb_state_e;

  typedef logic [1:0] sel_t;

endpackage

// File: rtl/mux4_stream_arbiter_if.sv
// Stream bundle: four requester ports in, one merged port out,
// plus grant status. master = producers/sink, slave = arbiter.
interface mux4_stream_arbiter_if #(
  parameter int WIDTH = 8
);
  import mux4_arb_pkg::*;

  logic [NREQ-1:0]            in_valid;
  logic [NREQ-1:0]            in_ready;
  logic [NREQ-1:0][WIDTH-1:0] in_data;
  logic [NREQ-1:0]            in_last;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH-1:0]           out_data;
  logic                       out_last;
  sel_t                       out_sel;
  logic                       busy;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_sel,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    output out_sel,
    output busy
  );

endinterface

// File: rtl/mux4_stream_arbiter_rr_pick4.sv
// Round-robin pick among 4 requests starting at ptr:
// rotate, priority-encode lowest, unrotate.
module rr_pick4
  import mux4_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  sel_t            ptr,
  output sel_t            gnt_idx,
  output logic            any
);

  logic [NREQ-1:0] rot;
  sel_t            off;

  always_comb begin
    rot = '0;
    for (int i = 0; i < NREQ; i++) begin
      rot[i] = req[sel_t'(i) + ptr];
    end
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = sel_t'(i);
    end
  end

  assign gnt_idx = off + ptr;
  assign any     = |req;

endmodule

// File: rtl/mux4_stream_arbiter.sv
// Round-robin packet arbiter: 4 valid/ready streams onto one,
// grant held until the granted packet's last beat transfers.
module mux4_stream_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mux4_stream_arbiter_if.slave bus
);

  arb_state_e       state;
  sel_t             ptr;
  sel_t             gnt_q;
  sel_t             pick;
  logic             any;
  logic             done;
  logic [WIDTH-1:0] data_sel;

  rr_pick4 u_pick (
    .req     (bus.in_valid),
    .ptr     (ptr),
    .gnt_idx (pick),
    .any     (any)
  );

  assign data_sel = bus.in_data[gnt_q];

  assign done = (state == BUSY)
             && bus.in_valid[gnt_q]
             && bus.out_ready
             && bus.in_last[gnt_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      gnt_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt_q <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          // next scan starts just past the finished requester
          if (done) begin
            ptr   <= gnt_q + sel_t'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    if (state == BUSY) begin
      bus.out_valid       = bus.in_valid[gnt_q];
      bus.out_data        = data_sel;
      bus.out_last        = bus.in_last[gnt_q];
      bus.in_ready[gnt_q] = bus.out_ready;
    end
  end

  assign bus.out_sel = gnt_q;
  assign bus.busy    = (state == BUSY);

endmodule

// File: tb/tb_mux4_stream_arbiter.sv
// Directed bench for mux4_stream_arbiter: arbitration order,
// stalls, mid-packet gaps and reset abandonment.
module tb_mux4_stream_arbiter;
  import mux4_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  logic [7:0] rxq[$];

  mux4_stream_arbiter_if #(.WIDTH(8)) bus ();

  mux4_stream_arbiter #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready)
      rxq.push_back(bus.out_data);
  end

  // {busy, sel, valid, last, in_ready, data}
  function automatic logic [16:0] snap();
    return {bus.busy, bus.out_sel, bus.out_valid,
            bus.out_last, bus.in_ready, bus.out_data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    logic [16:0] got;
    rst = 1'b1;
    bus.in_valid = '0;
    bus.in_last = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    settle();
    got = snap();
    checks++;
    if (got !== 17'h0)
      $display("FAIL reset_state got %h exp %h", got, 17'h0);
    else passed++;
    step();
    settle();
    got = snap();
    checks++;
    if (got !== 17'h0)
      $display("FAIL reset_idle got %h exp %h", got, 17'h0);
    else passed++;
  endtask

  task automatic test_single_req();
    logic [16:0] got, exp;
    logic [7:0]  d;
    logic        l;
    rxq.delete();
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b0100;
    bus.in_data[2] = 8'hA1;
    settle();
    got = snap();
    checks++;
    if (got !== 17'h0)
      $display("FAIL single_arb got %h exp %h", got, 17'h0);
    else passed++;
    step();
    for (int b = 0; b < 3; b++) begin
      d = 8'hA1 + 8'(b);
      l = (b == 2);
      bus.in_data[2] = d;
      bus.in_last[2] = l;
      settle();
      got = snap();
      exp = {1'b1, 2'd2, 1'b1, l, 4'b0100, d};
      checks++;
      if (got !== exp)
        $display("FAIL single_beat%0d got %h exp %h", b, got, exp);
      else passed++;
      step();
    end
    bus.in_valid = '0;
    bus.in_last = '0;
    settle();
    got = snap();
    exp = {1'b0, 2'd2, 1'b0, 1'b0, 4'b0000, 8'h00};
    checks++;
    if (got !== exp)
      $display("FAIL single_done got %h exp %h", got, exp);
    else passed++;
    checks++;
    if (rxq.size() != 3 || rxq[0] !== 8'hA1 || rxq[1] !== 8'hA2
        || rxq[2] !== 8'hA3)
      $display("FAIL single_rx got %0d beats exp 3", rxq.size());
    else passed++;
  endtask

  task automatic test_all_rr();
    logic [16:0] got, exp;
    sel_t order[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    sel_t prev;
    rxq.delete();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b1111;
    bus.in_last = 4'b1111;
    for (int i = 0; i < 4; i++) bus.in_data[i] = 8'h10 + 8'(i);
    prev = 2'd0;
    for (int k = 0; k < 6; k++) begin
      settle();
      got = snap();
      exp = {1'b0, prev, 1'b0, 1'b0, 4'b0000, 8'h00};
      checks++;
      if (got !== exp)
        $display("FAIL rr_idle%0d got %h exp %h", k, got, exp);
      else passed++;
      step();
      settle();
      got = snap();
      exp = {1'b1, order[k], 1'b1, 1'b1,
             4'(1 << order[k]), 8'h10 + 8'(order[k])};
      checks++;
      if (got !== exp)
        $display("FAIL rr_grant%0d got %h exp %h", k, got, exp);
      else passed++;
      prev = order[k];
      step();
    end
    bus.in_valid = '0;
    bus.in_last = '0;
    checks++;
    if (rxq.size() != 6 || rxq[0] !== 8'h10 || rxq[3] !== 8'h13
        || rxq[4] !== 8'h10 || rxq[5] !== 8'h11)
      $display("FAIL rr_rx got %0d beats exp 6", rxq.size());
    else passed++;
  endtask

  task automatic test_stall();
    logic [16:0] got, exp;
    logic rdy[7] = '{1, 1, 0, 0, 0, 1, 1};
    int   beat[7] = '{0, 1, 2, 2, 2, 2, 3};
    logic [7:0] d;
    logic l;
    rxq.delete();
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b0001;
    bus.in_data[0] = 8'h40;
    settle();
    step();
    for (int c = 0; c < 7; c++) begin
      d = 8'h40 + 8'(beat[c]);
      l = (beat[c] == 3);
      bus.in_data[0] = d;
      bus.in_last[0] = l;
      bus.out_ready = rdy[c];
      settle();
      got = snap();
      exp = {1'b1, 2'd0, 1'b1, l, rdy[c] ? 4'b0001 : 4'b0000, d};
      checks++;
      if (got !== exp)
        $display("FAIL stall_c%0d got %h exp %h", c, got, exp);
      else passed++;
      step();
    end
    bus.in_valid = '0;
    bus.in_last = '0;
    bus.out_ready = 1'b1;
    settle();
    got = snap();
    checks++;
    if (got !== 17'h0)
      $display("FAIL stall_done got %h exp %h", got, 17'h0);
    else passed++;
    checks++;
    if (rxq.size() != 4 || rxq[0] !== 8'h40 || rxq[1] !== 8'h41
        || rxq[2] !== 8'h42 || rxq[3] !== 8'h43)
      $display("FAIL stall_rx got %0d beats exp 4", rxq.size());
    else passed++;
  endtask

  task automatic test_drop();
    logic [16:0] got, exp;
    logic v1[5] = '{1, 0, 0, 1, 1};
    int   beat[5] = '{0, 1, 1, 1, 2};
    logic [7:0] d;
    logic l;
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b1011;
    bus.in_last = 4'b1001;
    bus.in_data[0] = 8'h50;
    bus.in_data[1] = 8'h51;
    bus.in_data[3] = 8'h5F;
    settle();
    step();
    for (int c = 0; c < 5; c++) begin
      d = 8'h51 + 8'(beat[c]);
      l = (beat[c] == 2);
      bus.in_valid[1] = v1[c];
      bus.in_data[1] = d;
      bus.in_last[1] = l;
      settle();
      got = snap();
      exp = {1'b1, 2'd1, v1[c], l, 4'b0010, d};
      checks++;
      if (got !== exp)
        $display("FAIL drop_c%0d got %h exp %h", c, got, exp);
      else passed++;
      step();
    end
    bus.in_valid = 4'b1001;
    bus.in_last[1] = 1'b0;
    settle();
    got = snap();
    exp = {1'b0, 2'd1, 1'b0, 1'b0, 4'b0000, 8'h00};
    checks++;
    if (got !== exp)
      $display("FAIL drop_idle got %h exp %h", got, exp);
    else passed++;
    step();
    settle();
    got = snap();
    exp = {1'b1, 2'd3, 1'b1, 1'b1, 4'b1000, 8'h5F};
    checks++;
    if (got !== exp)
      $display("FAIL drop_next got %h exp %h", got, exp);
    else passed++;
    step();
    bus.in_valid = '0;
    bus.in_last = '0;
  endtask

  task automatic test_reset_mid();
    logic [16:0] got, exp;
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b0100;
    bus.in_last = 4'b0100;
    bus.in_data[2] = 8'h60;
    settle();
    step();
    step();
    bus.in_last[2] = 1'b0;
    bus.in_data[2] = 8'h61;
    settle();
    step();
    settle();
    got = snap();
    exp = {1'b1, 2'd2, 1'b1, 1'b0, 4'b0100, 8'h61};
    checks++;
    if (got !== exp)
      $display("FAIL rstmid_beat1 got %h exp %h", got, exp);
    else passed++;
    step();
    bus.in_data[2] = 8'h62;
    bus.in_valid = 4'b1101;
    bus.in_last = 4'b1001;
    bus.in_data[0] = 8'h70;
    bus.in_data[3] = 8'h7F;
    rst = 1'b1;
    settle();
    step();
    rst = 1'b0;
    bus.in_valid = 4'b1001;
    settle();
    got = snap();
    checks++;
    if (got !== 17'h0)
      $display("FAIL rstmid_idle got %h exp %h", got, 17'h0);
    else passed++;
    step();
    settle();
    got = snap();
    exp = {1'b1, 2'd0, 1'b1, 1'b1, 4'b0001, 8'h70};
    checks++;
    if (got !== exp)
      $display("FAIL rstmid_grant got %h exp %h", got, exp);
    else passed++;
    step();
    bus.in_valid = '0;
    bus.in_last = '0;
  endtask

  initial begin
    test_reset();
    test_single_req();
    test_all_rr();
    test_stall();
    test_drop();
    test_reset_mid();
    step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
